// File: rtl/base_pkg.sv
// Shared nucleotide encoding and serializer FSM state type.
// Bases are 2-bit codes chosen so that complementing a base is a plain bitwise NOT.
package base_pkg;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_C = 2'b01;
  localparam base_t BASE_G = 2'b10;
  localparam base_t BASE_T = 2'b11;

  typedef enum logic {
    StIdle,
    StShift
  } ser_state_e;

  // A<->T, C<->G
  function automatic base_t base_comp(base_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/base_serializer_if.sv
// Word-in / base-out stream bundle for base_serializer.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface base_serializer_if
  import base_pkg::*;
#(
  parameter int unsigned B = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2*B-1:0] in_data;
  logic           in_dir;
  logic           in_comp;
  logic           out_valid;
  logic           out_ready;
  base_t          out_sym;
  logic           out_last;

  modport slave (
    input  in_valid, in_data, in_dir, in_comp, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );

  modport master (
    output in_valid, in_data, in_dir, in_comp, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/base_serializer.sv
// Serializes a packed word of B bases into one 2-bit base per beat, with selectable order
// and optional complement. Sustains one base per cycle across back-to-back words.
module base_serializer
  import base_pkg::*;
#(
  parameter int unsigned B = 4
) (
  input  logic               clk,
  input  logic               reset,
  base_serializer_if.slave   bus,
  output logic               busy
);

  localparam int unsigned W     = 2 * B;
  localparam int unsigned CNT_W = (B > 1) ? $clog2(B) : 1;

  ser_state_e       state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             comp_q, comp_d;

  base_t raw_sym;
  logic  accept;
  logic  xfer;

  always_comb begin
    raw_sym       = dir_q ? word_q[W-1 -: 2] : word_q[1:0];
    bus.out_valid = (state_q == StShift);
    bus.out_last  = bus.out_valid && (cnt_q == '0);
    bus.out_sym   = bus.out_valid ? (comp_q ? base_comp(raw_sym) : raw_sym) : BASE_A;
    // A new word may enter on the final beat so the stream has no bubble.
    bus.in_ready  = !reset && ((state_q == StIdle) || (bus.out_last && bus.out_ready));
    busy          = bus.out_valid;
    accept        = bus.in_valid && bus.in_ready;
    xfer          = bus.out_valid && bus.out_ready;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    comp_d  = comp_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          word_d  = bus.in_data;
          cnt_d   = CNT_W'(B - 1);
          dir_d   = bus.in_dir;
          comp_d  = bus.in_comp;
        end
      end
      StShift: begin
        if (accept) begin
          word_d = bus.in_data;
          cnt_d  = CNT_W'(B - 1);
          dir_d  = bus.in_dir;
          comp_d = bus.in_comp;
        end else if (xfer) begin
          if (bus.out_last) begin
            state_d = StIdle;
          end else begin
            word_d = dir_q ? (word_q << 2) : (word_q >> 2);
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      comp_q  <= comp_d;
    end
  end

endmodule

// File: tb/tb_base_serializer.sv
// Scoreboard bench for base_serializer at B=4 and B=1: beats are predicted on acceptance
// and compared on every output transfer.
module tb_base_serializer;

  logic clk = 1'b0;
  logic reset;
  logic busy4, busy1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [2:0] q4[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  base_serializer_if #(.B(4)) bus4 ();
  base_serializer_if #(.B(1)) bus1 ();

  base_serializer #(.B(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave),
    .busy  (busy4)
  );

  base_serializer #(.B(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave),
    .busy  (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected {last, sym} of beat i of a b-base word.
  function automatic logic [2:0] beat_of(input logic [7:0] data, input int unsigned b,
                                         input int unsigned i, input logic dir,
                                         input logic comp);
    int unsigned idx;
    logic [1:0]  s;
    idx = dir ? (b - 1 - i) : i;
    s   = data[2*idx +: 2];
    if (comp) s = ~s;
    return {(i == b - 1), s};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q4.delete();
      q1.delete();
    end else begin
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) check("sb4_unexpected_beat", 1, 0);
        else check("sb4_beat", {bus4.out_last, bus4.out_sym}, q4.pop_front());
      end
      if (bus4.in_valid && bus4.in_ready)
        for (int i = 0; i < 4; i++)
          q4.push_back(beat_of(bus4.in_data, 4, i, bus4.in_dir, bus4.in_comp));
      if (!bus4.out_valid) check("idle4_outputs", {bus4.out_last, bus4.out_sym}, 0);
      check("busy4", busy4, bus4.out_valid);

      if (bus1.out_valid && bus1.out_ready) begin
        if (q1.size() == 0) check("sb1_unexpected_beat", 1, 0);
        else check("sb1_beat", {bus1.out_last, bus1.out_sym}, q1.pop_front());
      end
      if (bus1.in_valid && bus1.in_ready)
        q1.push_back(beat_of({6'b0, bus1.in_data}, 1, 0, bus1.in_dir, bus1.in_comp));
      check("last1_eq_valid", bus1.out_last, bus1.out_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [7:0] data, input logic dir, input logic comp);
    bit ok = 0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = data;
    bus4.in_dir   = dir;
    bus4.in_comp  = comp;
    for (int k = 0; k < 20; k++) begin
      if (bus4.in_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) check("send4_timeout", 0, 1);
    step();
    bus4.in_valid = 1'b0;
    bus4.in_data  = 8'hFF;  // junk while not accepted
    bus4.in_dir   = ~dir;
    bus4.in_comp  = ~comp;
  endtask

  task automatic drain();
    bit ok = 0;
    bus4.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (q4.size() == 0 && q1.size() == 0 && !bus4.out_valid && !bus1.out_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  // Send word with dir=1, expect 4 consecutive beats starting the next cycle.
  task automatic burst_timing(input logic [7:0] data);
    send4(data, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("burst_valid", bus4.out_valid, 1);
      check("burst_last", bus4.out_last, (k == 3));
      step();
    end
    check("burst_done", bus4.out_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus4.in_valid = 0; bus4.in_data = '0; bus4.in_dir = 0; bus4.in_comp = 0;
    bus4.out_ready = 1;
    bus1.in_valid = 0; bus1.in_data = '0; bus1.in_dir = 0; bus1.in_comp = 0;
    bus1.out_ready = 1;
    step();
    step();
    check("rst_in_ready", bus4.in_ready, 0);
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_out_sym", bus4.out_sym, 0);
    check("rst_out_last", bus4.out_last, 0);
    check("rst_busy", busy4, 0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", bus4.in_ready, 1);

    // Order and complement variants.
    burst_timing(8'b00_01_10_11);
    send4(8'b00_01_10_11, 1'b0, 1'b0);
    drain();
    send4(8'b00_01_10_11, 1'b1, 1'b1);
    drain();

    // Backpressure during beat 2.
    send4(8'b00_01_10_11, 1'b1, 1'b0);
    step();
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_sym", bus4.out_sym, 2'b01);
      check("bp_valid", bus4.out_valid, 1);
      check("bp_in_ready", bus4.in_ready, 0);
      step();
    end
    drain();

    // Back-to-back words with in_valid held.
    bus4.in_valid = 1'b1;
    bus4.in_data  = 8'hE4;
    bus4.in_dir   = 1'b1;
    bus4.in_comp  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("b2b_in_ready", bus4.in_ready, (c == 0 || c == 4));
      check("b2b_valid", bus4.out_valid, (c != 0));
      check("b2b_last", bus4.out_last, (c == 4));
      step();
      if (c == 0) bus4.in_data = 8'h1B;
      if (c == 4) bus4.in_valid = 1'b0;
    end
    check("b2b_final_last", {bus4.out_valid, bus4.out_last}, 2'b11);
    drain();

    // Reset after beat 2 has transferred.
    send4(8'hA5, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_valid", bus4.out_valid, 0);
    check("midrst_in_ready", bus4.in_ready, 0);
    reset = 1'b0;
    #1;
    check("midrst_rel_ready", bus4.in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_residue", bus4.out_valid, 0);
      step();
    end
    send4(8'h36, 1'b1, 1'b1);
    drain();

    // B=1 back-to-back with complement.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 2'b10;
    bus1.in_comp  = 1'b1;
    step();
    bus1.in_data = 2'b01;
    check("b1_first_sym", bus1.out_sym, 2'b01);
    check("b1_in_ready_b2b", bus1.in_ready, 1);
    step();
    bus1.in_valid = 1'b0;
    check("b1_second_sym", bus1.out_sym, 2'b10);
    check("b1_second_last", bus1.out_last, 1);
    drain();

    // Random traffic with random backpressure on both instances.
    for (int k = 0; k < 200; k++) begin
      bus4.in_valid  = ($urandom_range(0, 1) == 1);
      bus4.in_data   = 8'($urandom);
      bus4.in_dir    = 1'($urandom);
      bus4.in_comp   = 1'($urandom);
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus1.in_valid  = ($urandom_range(0, 1) == 1);
      bus1.in_data   = 2'($urandom);
      bus1.in_comp   = 1'($urandom);
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus4.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    drain();
    check("end_q4_empty", q4.size(), 0);
    check("end_q1_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
